// File: rtl/dividend_rebuilder.sv
// Sequential signed shift-and-add unit: rebuilds dividend A = Q*B + R from a divider's outputs.
// Optional consistency check output err is enabled with `define DIVREBUILD_CONSIS_CHECK_EN.
module dividend_rebuilder #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] A,
  output logic             ovf,
  output logic             ready,
  output logic             done
`ifdef DIVREBUILD_CONSIS_CHECK_EN
  ,
  output logic             err
`endif
);

  // state   | meaning
  // IDLE    | waiting for start, ready high
  // CAPTURE | operands sampled every cycle while start stays high
  // LOAD    | magnitudes and product sign prepared, accumulator cleared
  // ITER    | one multiplier bit per cycle, WIDTH cycles
  // FIX     | sign applied, remainder added, A/ovf written
  // END     | done pulse, back to IDLE

  localparam int W2 = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_LOAD    = 3'd2,
    S_ITER    = 3'd3,
    S_FIX     = 3'd4,
    S_END     = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [W2-1:0]    r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sgn;
  logic [WIDTH-1:0] r_a;
  logic             r_ovf;

  logic [WIDTH-1:0] w_abs_q;
  logic [WIDTH-1:0] w_abs_b;
  logic [W2-1:0]    w_addend;
  logic [W2-1:0]    w_prod;
  logic [W2-1:0]    w_sum;
  logic [WIDTH:0]   w_top;
  logic             w_ovf;
  logic             w_last_iter;

  // Unsigned magnitudes: the most negative value maps cleanly to 2^(WIDTH-1).
  assign w_abs_q     = r_q[WIDTH-1] ? (~r_q + WIDTH'(1)) : r_q;
  assign w_abs_b     = r_b[WIDTH-1] ? (~r_b + WIDTH'(1)) : r_b;
  assign w_addend    = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
  assign w_prod      = r_sgn ? (~r_acc + W2'(1)) : r_acc;
  assign w_sum       = w_prod + {{WIDTH{r_r[WIDTH-1]}}, r_r};
  assign w_top       = w_sum[W2-1:WIDTH-1];
  assign w_ovf       = ~((&w_top) | (~|w_top));
  assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_CAPTURE;
      S_CAPTURE: if (!start) w_next = S_LOAD;
      S_LOAD:    w_next = S_ITER;
      S_ITER:    if (w_last_iter) w_next = S_FIX;
      S_FIX:     w_next = S_END;
      S_END:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign ready = (r_state == S_IDLE) || (r_state == S_END);
  assign done  = (r_state == S_END);
  assign A     = r_a;
  assign ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sgn    <= 1'b0;
      r_a      <= '0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_CAPTURE: begin
          r_q <= Q;
          r_b <= B;
          r_r <= R;
        end
        S_LOAD: begin
          r_mcand  <= w_abs_b;
          r_mplier <= w_abs_q;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_sgn    <= r_q[WIDTH-1] ^ r_b[WIDTH-1];
        end
        S_ITER: begin
          if (r_mplier[0]) r_acc <= r_acc + w_addend;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        S_FIX: begin
          r_a   <= w_sum[WIDTH-1:0];
          r_ovf <= w_ovf;
        end
        default: ;
      endcase
    end
  end

`ifdef DIVREBUILD_CONSIS_CHECK_EN
  logic [WIDTH-1:0] w_abs_r;
  logic             w_err;
  logic             r_err;

  // A triple is impossible from a truncating divider if the remainder is too large,
  // disagrees in sign with the dividend, or the dividend itself cannot be represented.
  assign w_abs_r = r_r[WIDTH-1] ? (~r_r + WIDTH'(1)) : r_r;
  assign w_err   = ((w_abs_r >= w_abs_b) && (r_b != '0))
                || ((r_r != '0) && (r_r[WIDTH-1] != w_sum[WIDTH-1]))
                || w_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (r_state == S_FIX) begin
      r_err <= w_err;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_dividend_rebuilder.sv
// Directed bench for dividend_rebuilder: arithmetic model of Q*B+R with a per-cycle compare process.
module tb_dividend_rebuilder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] Q;
  logic [15:0] B;
  logic [15:0] R;
  logic [15:0] A;
  logic        ovf;
  logic        ready;
  logic        done;
`ifdef DIVREBUILD_CONSIS_CHECK_EN
  logic        err;
`endif

  dividend_rebuilder #(.WIDTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .Q     (Q),
    .B     (B),
    .R     (R),
    .A     (A),
    .ovf   (ovf),
    .ready (ready),
    .done  (done)
`ifdef DIVREBUILD_CONSIS_CHECK_EN
    ,
    .err   (err)
`endif
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] b;
    logic [15:0] r;
    logic [15:0] a;
    logic        ovf;
    logic        err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic        ovf;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [15:0] last_a   = 16'h0000;
  logic        last_ovf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {ovf, A}: exact signed product plus remainder, then range test.
  function automatic logic [16:0] model(input logic [15:0] q, input logic [15:0] b, input logic [15:0] r);
    longint p;
    p = longint'($signed(q)) * longint'($signed(b)) + longint'($signed(r));
    model = {(p > 64'sd32767) || (p < -64'sd32768), p[15:0]};
  endfunction

  function automatic logic model_err(input logic [15:0] q, input logic [15:0] b, input logic [15:0] r);
    logic [16:0] m;
    int          ar;
    int          ab;
    m  = model(q, b, r);
    ar = $signed(r);
    ab = $signed(b);
    if (ar < 0) ar = -ar;
    if (ab < 0) ab = -ab;
    model_err = ((ar >= ab) && (ab != 0)) || ((r != 16'h0) && (r[15] != m[15])) || m[16];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done A=%h cyc=%0d", A, cyc);
        end else begin
          e = exp_q.pop_front();
          checks += 4;
          if (A !== e.a) begin failures++; $display("FAIL result_A got=%h want=%h", A, e.a); end
          if (ovf !== e.ovf) begin failures++; $display("FAIL result_ovf got=%b want=%b", ovf, e.ovf); end
          if (ready !== 1'b1) begin failures++; $display("FAIL ready_in_end got=%b want=1", ready); end
          if (cyc != e.due) begin failures++; $display("FAIL latency got_cyc=%0d want_cyc=%0d", cyc, e.due); end
`ifdef DIVREBUILD_CONSIS_CHECK_EN
          checks++;
          if (err !== e.err) begin failures++; $display("FAIL result_err got=%b want=%b", err, e.err); end
`endif
          last_a   = e.a;
          last_ovf = e.ovf;
        end
      end else if (exp_q.size() == 0) begin
        checks++;
        if (A !== last_a || ovf !== last_ovf) begin
          failures++;
          $display("FAIL hold got=%h/%b want=%h/%b", A, ovf, last_a, last_ovf);
        end
      end
    end
  end

  task automatic issue(input vec_t v);
    logic [16:0] m;
    exp_t        x;
    @(posedge clk); #2;
    start = 1'b1;
    if (v.hold <= 1) begin Q = v.q; B = v.b; R = v.r; end
    else begin Q = 16'h0101; B = 16'h0003; R = 16'h0001; end
    for (int i = 1; i < v.hold; i++) begin
      @(posedge clk); #2;
      if (i == v.hold - 1) begin Q = v.q; B = v.b; R = v.r; end
      else begin Q = Q + 16'h0011; B = B + 16'h0002; R = R ^ 16'h0001; end
    end
    @(posedge clk); #2;
    start = 1'b0;
    m     = model(v.q, v.b, v.r);
    x.a   = m[15:0];
    x.ovf = m[16];
    x.err = model_err(v.q, v.b, v.r);
    x.due = cyc + 19;
    exp_q.push_back(x);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL timeout_%s pending=%0d want=0", name, exp_q.size());
      exp_q.delete();
    end
    #2;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [16:0] m;
    m = model(v.q, v.b, v.r);
    checks += 2;
    if (m[15:0] !== v.a || m[16] !== v.ovf) begin
      failures++;
      $display("FAIL model_pin_%s got=%h/%b want=%h/%b", name, m[15:0], m[16], v.a, v.ovf);
    end
    if (model_err(v.q, v.b, v.r) !== v.err) begin
      failures++;
      $display("FAIL model_err_pin_%s want=%b", name, v.err);
    end
    issue(v);
    wait_idle(name);
    checks += 2;
    if (A !== v.a) begin failures++; $display("FAIL lit_A_%s got=%h want=%h", name, A, v.a); end
    if (ovf !== v.ovf) begin failures++; $display("FAIL lit_ovf_%s got=%b want=%b", name, ovf, v.ovf); end
`ifdef DIVREBUILD_CONSIS_CHECK_EN
    checks++;
    if (err !== v.err) begin failures++; $display("FAIL lit_err_%s got=%b want=%b", name, err, v.err); end
`endif
  endtask

  function automatic vec_t mk(input logic [15:0] q, input logic [15:0] b, input logic [15:0] r,
                              input logic [15:0] a, input logic o, input logic er, input int hold);
    mk.q = q; mk.b = b; mk.r = r; mk.a = a; mk.ovf = o; mk.err = er; mk.hold = hold;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    vec_t v;
    start = 1'b0; Q = '0; B = '0; R = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 4;
    if (A !== 16'h0) begin failures++; $display("FAIL reset_A got=%h want=0000", A); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", ready); end
    @(posedge clk); #2;
    rst_n = 1'b1;

    vecs.push_back(mk(16'h0003, 16'h0002, 16'h0001, 16'h0007, 1'b0, 1'b0, 1));
    vecs.push_back(mk(16'hFFFD, 16'h0002, 16'hFFFF, 16'hFFF9, 1'b0, 1'b0, 1));
    vecs.push_back(mk(16'hFFFD, 16'hFFFE, 16'h0001, 16'h0007, 1'b0, 1'b0, 1));
    vecs.push_back(mk(16'h0003, 16'hFFFE, 16'hFFFF, 16'hFFF9, 1'b0, 1'b0, 1));
    vecs.push_back(mk(16'h000A, 16'h000A, 16'h0000, 16'h0064, 1'b0, 1'b0, 5));
    vecs.push_back(mk(16'h1234, 16'h0000, 16'h0005, 16'h0005, 1'b0, 1'b0, 1));
    vecs.push_back(mk(16'h4000, 16'h0004, 16'h0000, 16'h0000, 1'b1, 1'b1, 1));
    vecs.push_back(mk(16'h8000, 16'h0001, 16'h0000, 16'h8000, 1'b0, 1'b0, 1));
    vecs.push_back(mk(16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b1, 1'b1, 2));
    vecs.push_back(mk(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0001, 1'b1, 1'b1, 1));
    vecs.push_back(mk(16'h0000, 16'hFFFF, 16'hFFF0, 16'hFFF0, 1'b0, 1'b1, 1));
    vecs.push_back(mk(16'h0001, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b1, 1));
    vecs.push_back(mk(16'h0002, 16'h0003, 16'h0001, 16'h0007, 1'b0, 1'b0, 3));
    vecs.push_back(mk(16'hFFFE, 16'h0003, 16'h0001, 16'hFFFB, 1'b0, 1'b1, 1));
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // start raised during END must not launch another operation
    v = mk(16'h0006, 16'h0007, 16'h0002, 16'h002C, 1'b0, 1'b0, 1);
    issue(v);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (25) @(posedge clk);
    #2;
    checks += 2;
    if (ready !== 1'b1) begin failures++; $display("FAIL end_start_ready got=%b want=1", ready); end
    if (A !== 16'h002C) begin failures++; $display("FAIL end_start_A got=%h want=002C", A); end

    // reset during ITER cycle 7 aborts with no partial result
    v = mk(16'h7FFF, 16'h0003, 16'h0000, 16'h7FFD, 1'b1, 1'b1, 1);
    issue(v);
    repeat (8) @(posedge clk);
    #3;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL busy_ready got=%b want=0", ready); end
    rst_n = 1'b0;
    exp_q.delete();
    last_a   = 16'h0;
    last_ovf = 1'b0;
    #1;
    checks += 4;
    if (A !== 16'h0) begin failures++; $display("FAIL abort_A got=%h want=0000", A); end
    if (ovf !== 1'b0) begin failures++; $display("FAIL abort_ovf got=%b want=0", ovf); end
    if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done); end
    if (ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b want=1", ready); end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run_vec(mk(16'h0005, 16'h0005, 16'h0002, 16'h001B, 1'b0, 1'b0, 1), "after_reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dividend_rebuilder.md
Name: dividend_rebuilder

Overview:
- Sequential signed shift-and-add unit that runs the divider backwards: it takes quotient Q, divisor B and remainder R and rebuilds dividend A = Q*B + R.
- Sits beside the restoring divider on the same 8-bit-bus accelerator. It shares the same start/ready handshake and is used for self-check and for software that needs the inverse operation.
- Uses truncated-division sign rules: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement).
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; operands are captured while it is high.
- Q, input, WIDTH, signed quotient.
- B, input, WIDTH, signed divisor.
- R, input, WIDTH, signed remainder.
- A, output, WIDTH, signed rebuilt dividend (registered).
- ovf, output, 1, result did not fit in signed WIDTH; valid with A.
- ready, output, 1, high in IDLE and END.
- done, output, 1, one-cycle pulse in END.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state = IDLE; A = 0, ovf = 0, done = 0, ready = 1.
  - Accumulator, counter and operand registers = 0.
  - Reset mid-operation aborts with no partial result.
- States: IDLE, CAPTURE, LOAD, ITER, FIX, END.
- IDLE:
  - ready = 1.
  - start = 1 → CAPTURE.
- CAPTURE:
  - Q, B and R registers load every cycle.
  - start still high → stay; start low → LOAD.
  - The operands used are the values present in the last cycle of CAPTURE.
- LOAD:
  - Multiplicand register = |B|; multiplier shift register = |Q| (unsigned WIDTH bits, so |−2^(WIDTH−1)| = 2^(WIDTH−1)).
  - 2*WIDTH accumulator = 0; counter = 0; latch sgn = Q[MSB] XOR B[MSB].
  - → ITER.
- ITER (one cycle per multiplier bit, WIDTH cycles in total):
  - If multiplier LSB = 1, add multiplicand << counter into the accumulator.
  - Shift multiplier right by 1; increment counter.
  - Leave ITER after the WIDTH-th cycle → FIX.
- FIX:
  - p = sgn ? −acc : acc (2*WIDTH bits).
  - s = p + sign-extended R.
  - A ← s[WIDTH−1:0].
  - ovf ← 1 if s[2*WIDTH−1:WIDTH−1] is not all equal, else 0.
  - → END.
- END:
  - ready = 1, done = 1 for exactly one cycle.
  - → IDLE unconditionally; start in END is ignored.
- Latency: first LOAD cycle to END = WIDTH+2 cycles (18 at default).
- A and ovf hold until the next FIX or reset. A is not cleared by a new start.
- start is ignored in LOAD, ITER, FIX and END; there is no queuing.
- B = 0 is legal: result = R, ovf = 0. Q = 0 is legal: result = R.
- No divisor-zero abort; unlike the divider, every request completes.

Optional Feature:
- Macro: DIVREBUILD_CONSIS_CHECK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0, written in FIX, valid with A).
  - err = 1 if |R| >= |B| with B != 0, or if R != 0 and R[MSB] != A[MSB], or if ovf = 1.
  - Flags Q/B/R triples the divider could never produce.
- Undefined:
  - No err port and no check logic.
  - All other behaviour identical.

Test Plan:
- Q=3, B=2, R=1, start high 1 cycle → done after 18 cycles from LOAD; A=0x0007, ovf=0, ready=1 in END and IDLE.
- Q=0xFFFD (−3), B=2, R=0xFFFF (−1) → A=0xFFF9 (−7); Q=0xFFFD, B=0xFFFE, R=1 → A=0x0007; Q=3, B=0xFFFE, R=0xFFFF → A=0xFFF9.
- start held 5 cycles with operands changing each cycle → the last-cycle operands (Q=10, B=10, R=0) are used; A=0x0064; exactly one done pulse.
- B=0, Q=0x1234, R=5 → A=0x0005, ovf=0. Q=0x4000, B=4, R=0 → A=0x0000, ovf=1. Q=0x8000, B=1, R=0 → A=0x8000, ovf=0.
- Drive rst_n low during ITER cycle 7 → A=0, ovf=0, done=0, ready=1 immediately. After release, a new request Q=5, B=5, R=2 → A=0x001B.
- With DIVREBUILD_CONSIS_CHECK_EN: Q=1, B=3, R=4 → A=7, err=1. Q=2, B=3, R=1 → A=7, err=0. Q=0xFFFE, B=3, R=1 → A=0xFFFB, err=1 (sign mismatch).
